cache_ctrl_dm: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate data cache between the CPU memory port (addr / write_data / read_or_write / memory_sig / read_data / finish) and the line-granular DRAM request/response FIFO path.
- Generalises the fixed single-word cache controller: line size and line count are parameters, and dirty lines are evicted as whole lines.
- Runs entirely in the CPU clock domain; the clock crossing stays in the existing FIFO path.

---
 rtl/cache_ctrl_dm.sv | 205 ++++++++++++++++++++
 tb/tb_cache_ctrl_dm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// CPU side: single-word load/store with a one-cycle strobe and finish pulse.
// Memory side: whole-line requests (line read for refill, line write for eviction).
// Optional build macro CACHE_STATS_EN adds hit/miss/write-back counters.
module cache_ctrl_dm #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = ADDR_W - 2 - OFF_W - IDX_W,
  localparam int LINE_W    = DATA_W * LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_or_write,
  input  logic              memory_sig,
  output logic [DATA_W-1:0] read_data,
  output logic              finish,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
`endif
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, RF_REQ, RF_WAIT, RESPOND} state_t;

  state_t state_q, state_d;

  // Tag and data arrays plus per-line status bits.
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  // Latched request and the line read out of the arrays for it.
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  logic [DATA_W-1:0] req_wdata;
  logic              req_read;
  logic              replay_q;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;

  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  addr_idx;
  logic              hit;
  logic              victim_dirty;
  logic              req_fire;
  logic [LINE_W-1:0] merged_line;
  logic [ADDR_W-1:0] req_line_addr;
  logic [ADDR_W-1:0] victim_line_addr;
  logic              unused_addr_lsbs;

  assign addr_tag         = addr[ADDR_W-1 -: TAG_W];
  assign addr_idx         = addr[OFF_W+IDX_W+1 : OFF_W+2];
  assign unused_addr_lsbs = ^addr[1:0];

  assign hit              = valid_q[req_idx] && (rd_tag == req_tag);
  assign victim_dirty     = valid_q[req_idx] && dirty_q[req_idx];
  assign req_fire         = mem_req_valid && mem_req_ready;
  assign req_line_addr    = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
  assign victim_line_addr = {rd_tag, req_idx, {(OFF_W+2){1'b0}}};

  // Current line with the store word spliced in, for write hits.
  always_comb begin
    merged_line = rd_line;
    merged_line[req_off*DATA_W +: DATA_W] = req_wdata;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default first keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (memory_sig) state_d = LOOKUP;
      LOOKUP: begin
        if (hit)               state_d = RESPOND;
        else if (victim_dirty) state_d = WB;
        else                   state_d = RF_REQ;
      end
      WB:      if (req_fire)      state_d = RF_REQ;
      RF_REQ:  if (req_fire)      state_d = RF_WAIT;
      RF_WAIT: if (mem_rsp_valid) state_d = LOOKUP;
      RESPOND:                    state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Array storage, request latch and array read port.
  always_ff @(posedge clk) begin
    // NOTE: tag/data arrays are deliberately not reset; valid_q gates their contents.
    if (state_q == IDLE && memory_sig) begin
      req_tag   <= addr_tag;
      req_idx   <= addr_idx;
      req_off   <= addr[OFF_W+1:2];
      req_wdata <= write_data;
      req_read  <= read_or_write;
      rd_tag    <= tag_mem[addr_idx];
      rd_line   <= data_mem[addr_idx];
    end
    if (state_q == LOOKUP && hit && !req_read) begin
      data_mem[req_idx] <= merged_line;
    end
    if (state_q == RF_WAIT && mem_rsp_valid) begin
      data_mem[req_idx] <= mem_rsp_rdata;
      tag_mem[req_idx]  <= req_tag;
      rd_line           <= mem_rsp_rdata;
      rd_tag            <= req_tag;
    end
  end

  // Valid/dirty bits and the replay marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      dirty_q  <= '0;
      replay_q <= 1'b0;
    end else begin
      if (state_q == IDLE && memory_sig)         replay_q <= 1'b0;
      if (state_q == LOOKUP && hit && !req_read) dirty_q[req_idx] <= 1'b1;
      if (state_q == RF_WAIT && mem_rsp_valid) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
        replay_q         <= 1'b1;
      end
    end
  end

  // CPU response and memory request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      finish        <= 1'b0;
      read_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
    end else begin
      finish <= (state_q == RESPOND);
      case (state_q)
        LOOKUP: begin
          if (hit) begin
            if (req_read) read_data <= rd_line[req_off*DATA_W +: DATA_W];
          end else begin
            mem_req_valid <= 1'b1;
            if (victim_dirty) begin
              mem_req_we    <= 1'b1;
              mem_req_addr  <= victim_line_addr;
              mem_req_wdata <= rd_line;
            end else begin
              mem_req_we    <= 1'b0;
              mem_req_addr  <= req_line_addr;
            end
          end
        end
        // The refill request follows the posted write-back without a gap.
        WB: if (req_fire) begin
          mem_req_we   <= 1'b0;
          mem_req_addr <= req_line_addr;
        end
        RF_REQ: if (req_fire) mem_req_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Statistics: first-pass lookups only, plus write-back handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state_q == LOOKUP && !replay_q) begin
        if (hit) hit_count  <= hit_count + 32'd1;
        else     miss_count <= miss_count + 32'd1;
      end
      if (state_q == WB && req_fire) wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Directed bench for cache_ctrl_dm (LINE_WORDS=4, NUM_LINES=16) with an
// instant-ready line memory and a refill latency of 3 cycles.
module tb_cache_ctrl_dm;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic              read_or_write;
  logic              memory_sig;
  logic [DATA_W-1:0] read_data;
  logic              finish;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid = 1'b0;
  logic [LINE_W-1:0] mem_rsp_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]       hit_count, miss_count, wb_count;
`endif

  cache_ctrl_dm #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(4), .NUM_LINES(16)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .read_or_write(read_or_write), .memory_sig(memory_sig),
    .read_data(read_data), .finish(finish),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line memory model and handshake log.
  logic [LINE_W-1:0] dram [logic [ADDR_W-1:0]];
  bit                hs_we   [$];
  logic [ADDR_W-1:0] hs_addr [$];
  logic [LINE_W-1:0] hs_wdata[$];
  int                rsp_cnt = 0;

  // Observe handshakes mid-cycle and return refill data 3 edges after a read handshake.
  always @(negedge clk) begin
    #1;
    mem_rsp_valid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) mem_rsp_valid = 1'b1;
    end
    if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1 && rst === 1'b0) begin
      hs_we.push_back(mem_req_we);
      hs_addr.push_back(mem_req_addr);
      hs_wdata.push_back(mem_req_wdata);
      if (mem_req_we) begin
        dram[mem_req_addr] = mem_req_wdata;
      end else begin
        mem_rsp_rdata = dram.exists(mem_req_addr) ? dram[mem_req_addr] : {4{32'hBAD0_0000}};
        rsp_cnt = 3;
      end
    end
  end

  // Wait for finish from a negedge whose cycle number is start; returns latency and data.
  task automatic wait_finish(input int start, output int lat, output logic [31:0] rdat);
    int cyc = start;
    while (finish !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (finish !== 1'b1) check("finish_timeout", 160'(finish), 160'd1);
    lat  = cyc;
    rdat = read_data;
  endtask

  // Issue one access starting at the current negedge.
  task automatic access(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic rd,
                        output int lat, output logic [31:0] rdat);
    addr          = a;
    write_data    = d;
    read_or_write = rd;
    memory_sig    = 1'b1;
    @(negedge clk);
    memory_sig = 1'b0;
    wait_finish(0, lat, rdat);
  endtask

  localparam logic [LINE_W-1:0] LINE_40  = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [LINE_W-1:0] LINE_440 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [LINE_W-1:0] WB_40    = {32'h44, 32'hDEADBEEF, 32'h22, 32'h11};
  localparam logic [LINE_W-1:0] WB_440   = {32'hA3, 32'hA2, 32'h12345678, 32'hA0};

  initial begin
    int          lat;
    int          hs0;
    logic [31:0] rdat;
    logic        saw_finish;

    dram[27'h40]  = LINE_40;
    dram[27'h440] = LINE_440;
    rst = 1'b1; addr = '0; write_data = '0; read_or_write = 1'b1;
    memory_sig = 1'b0; mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_finish",    160'(finish),        160'd0);
    check("rst_read_data", 160'(read_data),     160'd0);
    check("rst_req_ctl",   160'({mem_req_valid, mem_req_we, mem_req_addr}), 160'd0);
    check("rst_req_wdata", 160'(mem_req_wdata), 160'd0);
    rst = 1'b0;

    // Cold read miss: one line read at 0x40, clean-miss latency 4+0+3.
    access(27'h40, 32'h0, 1'b1, lat, rdat);
    check("miss40_lat",  160'(lat),  160'd7);
    check("miss40_data", 160'(rdat), 160'h11);
    check("miss40_nreq", 160'(hs_addr.size()), 160'd1);
    check("miss40_req",  160'({hs_we[0], hs_addr[0]}), 160'({1'b0, 27'h40}));

    // Back-to-back read hit on the same line.
    access(27'h44, 32'h0, 1'b1, lat, rdat);
    check("hit44_lat",  160'(lat),  160'd2);
    check("hit44_data", 160'(rdat), 160'h22);

    // Write hit, no memory traffic, finish lasts one cycle.
    access(27'h48, 32'hDEADBEEF, 1'b0, lat, rdat);
    check("whit48_lat",  160'(lat), 160'd2);
    check("whit48_nreq", 160'(hs_addr.size()), 160'd1);
    @(negedge clk);
    check("finish_pulse", 160'(finish), 160'd0);

    access(27'h48, 32'h0, 1'b1, lat, rdat);
    check("rhit48_lat",  160'(lat),  160'd2);
    check("rhit48_data", 160'(rdat), 160'hDEADBEEF);

    // Conflict miss on a dirty line: write-back of 0x40, then refill of 0x440.
    access(27'h440, 32'h0, 1'b1, lat, rdat);
    check("dmiss440_lat",  160'(lat),  160'd8);
    check("dmiss440_data", 160'(rdat), 160'hA0);
    check("dmiss440_nreq", 160'(hs_addr.size()), 160'd3);
    check("wb40_req",      160'({hs_we[1], hs_addr[1]}), 160'({1'b1, 27'h40}));
    check("wb40_wdata",    160'(hs_wdata[1]), 160'(WB_40));
    check("rf440_req",     160'({hs_we[2], hs_addr[2]}), 160'({1'b0, 27'h440}));

    // Dirty the new line, then stall the write-back for 5 cycles.
    access(27'h444, 32'h12345678, 1'b0, lat, rdat);
    check("whit444_lat", 160'(lat), 160'd2);
`ifdef CACHE_STATS_EN
    check("stat_hit_a",  160'(hit_count),  160'd4);
    check("stat_miss_a", 160'(miss_count), 160'd2);
    check("stat_wb_a",   160'(wb_count),   160'd1);
`endif
    hs0 = hs_addr.size();
    mem_req_ready = 1'b0;
    addr = 27'h40; read_or_write = 1'b1; memory_sig = 1'b1;
    @(negedge clk);
    memory_sig = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("wb_hold_ctl",   160'({mem_req_valid, mem_req_we, mem_req_addr}), 160'({1'b1, 1'b1, 27'h440}));
      check("wb_hold_wdata", 160'(mem_req_wdata), 160'(WB_440));
    end
    mem_req_ready = 1'b1;
    wait_finish(6, lat, rdat);
    check("stall_lat",  160'(lat),  160'd13);
    check("stall_data", 160'(rdat), 160'h11);
    check("stall_nreq", 160'(hs_addr.size() - hs0), 160'd2);
    check("stall_wb",   160'({hs_we[hs0], hs_addr[hs0]}), 160'({1'b1, 27'h440}));
    check("stall_rf",   160'({hs_we[hs0+1], hs_addr[hs0+1]}), 160'({1'b0, 27'h40}));
`ifdef CACHE_STATS_EN
    check("stat_hit_b",  160'(hit_count),  160'd4);
    check("stat_miss_b", 160'(miss_count), 160'd3);
    check("stat_wb_b",   160'(wb_count),   160'd2);
`endif

    // Reset one cycle into RF_WAIT of a miss to 0x80; the late response lands in IDLE.
    addr = 27'h80; memory_sig = 1'b1;
    @(negedge clk);
    memory_sig = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_req_valid", 160'(mem_req_valid), 160'd0);
    saw_finish = finish;
    repeat (3) begin
      @(negedge clk);
      saw_finish = saw_finish | finish;
    end
    check("abort_no_finish", 160'(saw_finish), 160'd0);
`ifdef CACHE_STATS_EN
    check("stat_clear", 160'({hit_count, miss_count, wb_count}), 160'd0);
`endif

    // Valid bits were cleared: 0x40 misses again with a fresh read request.
    hs0 = hs_addr.size();
    access(27'h40, 32'h0, 1'b1, lat, rdat);
    check("post_rst_lat",  160'(lat),  160'd7);
    check("post_rst_data", 160'(rdat), 160'h11);
    check("post_rst_nreq", 160'(hs_addr.size() - hs0), 160'd1);
    check("post_rst_req",  160'({hs_we[hs0], hs_addr[hs0]}), 160'({1'b0, 27'h40}));
`ifdef CACHE_STATS_EN
    check("stat_hit_c",  160'(hit_count),  160'd0);
    check("stat_miss_c", 160'(miss_count), 160'd1);
    check("stat_wb_c",   160'(wb_count),   160'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
